uart_tx_serializer: RTL and testbench

UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

---
 rtl/uart_tx_serializer.sv | 145 ++++++++++++++
 tb/tb_uart_tx_serializer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmitter: start bit, DATA_W data bits LSB first, optional even parity, one stop bit.
// Define UART_TX_PARITY_EN to insert the even-parity bit between the data bits and the stop bit.
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_line,
  output logic              busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic               tx_line_q;
  logic               tx_ready_q;
  logic               busy_q;
  logic               bit_end;
`ifdef UART_TX_PARITY_EN
  logic               parity_q;
`endif

  // The bit counter wraps to zero on the last cycle of every slot, so slots never drift.
  assign bit_end = (cnt_q == CNT_LAST);
  assign cnt_d   = bit_end ? '0 : cnt_q + CNT_W'(1);
  assign shift_d = shift_q >> 1;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      tx_line_q  <= 1'b1;
      tx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          idx_q <= '0;
          if (tx_valid && tx_ready_q) begin
            shift_q    <= tx_data;
`ifdef UART_TX_PARITY_EN
            parity_q   <= ^tx_data;
`endif
            state_q    <= ST_START;
            tx_line_q  <= 1'b0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end else begin
            tx_line_q  <= 1'b1;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end
        end

        ST_START: begin
          cnt_q <= cnt_d;
          if (bit_end) begin
            state_q   <= ST_DATA;
            idx_q     <= '0;
            tx_line_q <= shift_q[0];
            shift_q   <= shift_d;
          end
        end

        ST_DATA: begin
          cnt_q <= cnt_d;
          if (bit_end) begin
            if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_q   <= ST_PARITY;
              tx_line_q <= parity_q;
`else
              state_q   <= ST_STOP;
              tx_line_q <= 1'b1;
`endif
            end else begin
              idx_q     <= idx_q + IDX_W'(1);
              tx_line_q <= shift_q[0];
              shift_q   <= shift_d;
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          cnt_q <= cnt_d;
          if (bit_end) begin
            state_q   <= ST_STOP;
            tx_line_q <= 1'b1;
          end
        end
`endif

        ST_STOP: begin
          cnt_q <= cnt_d;
          if (bit_end) begin
            state_q    <= ST_IDLE;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end
        end

        default: begin
          state_q    <= ST_IDLE;
          tx_line_q  <= 1'b1;
          tx_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign tx_line  = tx_line_q;
  assign tx_ready = tx_ready_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer (CLKS_PER_BIT=4, DATA_W=8); honours UART_TX_PARITY_EN.
module tb_uart_tx_serializer;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NSLOT = 11;
`else
  localparam int NSLOT = 10;
`endif
  localparam int FRAME_CYC = NSLOT * CPB;

  typedef struct packed {
    logic [7:0] data;
    logic [9:0] line;   // slot i = bit i: start, d0..d7, stop
    logic       par;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_line, busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int frames_done = 0;
  logic [10:0] exp_q[$];
  int start_q[$];
  vec_t vecs[6];

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_line(tx_line), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [10:0] mk_slots(input logic [9:0] line, input logic par);
    logic [10:0] s;
    s = {1'b0, line};
`ifdef UART_TX_PARITY_EN
    s = {line[9], par, line[8:0]};
`endif
    return s;
  endfunction

  function automatic logic [10:0] model(input logic [7:0] d);
    return mk_slots({1'b1, d, 1'b0}, ^d);
  endfunction

  // Samples one frame starting at the negedge where the start bit was first seen.
  task automatic capture_frame();
    logic [10:0] got = '0;
    logic        steady = 1'b1;
    logic        aborted = 1'b0;
    int          i = 0;
    start_q.push_back(cyc);
    while (i < FRAME_CYC && !aborted) begin
      if (i != 0) @(negedge clk);
      if (rst) aborted = 1'b1;
      else begin
        if (i % CPB == 0) got[i / CPB] = tx_line;
        else if (tx_line !== got[i / CPB]) steady = 1'b0;
        if (busy !== 1'b1 || tx_ready !== 1'b0) steady = 1'b0;
        i++;
      end
    end
    if (!aborted) begin
      @(negedge clk);
      check("idle_after_frame", {tx_line, busy, tx_ready}, 3'b101);
      check("slots_steady_busy", steady, 1'b1);
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_frame: got 0x%0h expected no frame", got);
      end else begin
        logic [10:0] e = exp_q.pop_front();
        if (got !== e) begin
          n_err++;
          $display("FAIL frame_slots: got 0x%0h expected 0x%0h", got, e);
        end
      end
      frames_done++;
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst && tx_line === 1'b0) capture_frame();
    end
  end

  task automatic send(input logic [7:0] d, input logic [10:0] e);
    int n = 0;
    while (tx_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("send_ready_wait", tx_ready, 1'b1);
    tx_data  = d;
    tx_valid = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    tx_valid = 1'b0;
    check("accept_start_bit", {tx_line, busy, tx_ready}, 3'b010);
  endtask

  task automatic wait_frames(input int target);
    int n = 0;
    while (frames_done < target && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("frames_done", frames_done, target);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int   exp_frames = 0;
    int   base;
    int   n;
    logic stayed;

    vecs[0] = '{8'hA5, 10'b1101001010, 1'b0};
    vecs[1] = '{8'h01, 10'b1000000010, 1'b1};
    vecs[2] = '{8'h00, 10'b1000000000, 1'b0};
    vecs[3] = '{8'hFF, 10'b1111111110, 1'b0};
    vecs[4] = '{8'h80, 10'b1100000000, 1'b1};
    vecs[5] = '{8'h55, 10'b1010101010, 1'b0};

    // Reset: applied between clock edges, must take effect without a clock.
    #1 rst = 1'b1;
    #2 check("reset_async", {tx_line, busy, tx_ready}, 3'b100);
    repeat (3) @(negedge clk);
    check("reset_held_ready_low", tx_ready, 1'b0);
    rst = 1'b0;
    #1 check("ready_low_until_edge", tx_ready, 1'b0);
    @(negedge clk);
    check("ready_after_reset", {tx_line, busy, tx_ready}, 3'b101);

    foreach (vecs[k]) begin
      send(vecs[k].data, mk_slots(vecs[k].line, vecs[k].par));
      exp_frames++;
      wait_frames(exp_frames);
    end

    // Back-to-back with tx_valid held: one idle cycle between frames, second carries 0xC3.
    base = start_q.size();
    n = 0;
    while (tx_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    exp_q.push_back(model(8'h3C));
    @(negedge clk);
    tx_data = 8'hC3;
    exp_q.push_back(model(8'hC3));
    n = 0;
    do begin @(negedge clk); n++; end while (tx_ready !== 1'b1 && n < 200);
    @(negedge clk);
    tx_valid = 1'b0;
    exp_frames += 2;
    wait_frames(exp_frames);
    if (start_q.size() >= base + 2)
      check("b2b_gap", start_q[base + 1] - start_q[base], FRAME_CYC + 1);
    else
      check("b2b_frame_count", start_q.size(), base + 2);

    // Input changes and a valid pulse during DATA must not disturb the frame.
    send(8'hFF, model(8'hFF));
    repeat (10) @(negedge clk);
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    @(negedge clk);
    check("ignore_valid_in_data", {busy, tx_ready}, 2'b10);
    tx_valid = 1'b0;
    exp_frames++;
    wait_frames(exp_frames);
    stayed = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (tx_line !== 1'b1) stayed = 1'b0;
    end
    check("no_second_accept", stayed, 1'b1);

    // Asynchronous reset in DATA bit 3, then a clean 0x5A frame.
    send(8'h5A, model(8'h5A));
    repeat (17) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("rst_mid_frame_async", {tx_line, busy, tx_ready}, 3'b100);
    repeat (3) @(negedge clk);
    exp_q.delete();
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_abort", {tx_line, busy, tx_ready}, 3'b101);
    send(8'h5A, model(8'h5A));
    exp_frames++;
    wait_frames(exp_frames);

    repeat (4) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
